// File: rtl/branch_redirect_unit_pkg.sv
// Shared types and constants for the branch redirect unit.
package branch_redirect_unit_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } bru_state_t;

  localparam logic [63:0] PC_STEP          = 64'd4;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

endpackage

// File: rtl/branch_redirect_unit_sat_counter.sv
// Width-parameterised saturating up-counter with synchronous reset.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count increments; once all-ones it sticks there until reset.
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + W'(1);
  end

endmodule

// File: rtl/branch_redirect_unit.sv
// Owns the fetch PC: sequential advance, stall hold, and redirect on a taken
// branch, plus the wrong-path flush pulses and branch bookkeeping.
module branch_redirect_unit
  import branch_redirect_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic [63:0]      br_target,
  output logic [63:0]      pc,
  output logic             pc_valid,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [CNT_W-1:0] taken_count,
  output logic             misalign_err
);

  // Flush countdown starts at FLUSH_CYCLES-1 so the pulse spans exactly
  // FLUSH_CYCLES cycles (legal range 1..4 fits in two bits).
  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

  bru_state_t  state, state_nxt;
  logic [1:0]  fcnt, fcnt_nxt;
  logic [63:0] pc_q, pc_nxt;
  logic        flush_q, flush_nxt;
  logic        mis_q, mis_nxt;
  logic        accept;

  // A branch from a squashed (flushing) instruction must never redirect.
  assign accept = br_valid & br_taken & (state == RUN);

  // Next-state: redirect wins over stall; otherwise advance unless stalled,
  // and run the flush countdown independent of stall.
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    flush_nxt = flush_q;
    mis_nxt   = mis_q;
    pc_nxt    = stall ? pc_q : pc_q + PC_STEP;
    if (accept) begin
      pc_nxt    = {br_target[63:2], 2'b00};
      flush_nxt = 1'b1;
      state_nxt = FLUSH;
      fcnt_nxt  = FLUSH_INIT;
      if (br_target[1:0] != 2'b00)
        mis_nxt = 1'b1;
    end else if (state == FLUSH) begin
      if (fcnt != 2'd0) begin
        fcnt_nxt = fcnt - 2'd1;
      end else begin
        flush_nxt = 1'b0;
        state_nxt = RUN;
      end
    end
  end

  // State register; reset overrides everything, including an active flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      fcnt    <= 2'd0;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      fcnt    <= fcnt_nxt;
      pc_q    <= pc_nxt;
      flush_q <= flush_nxt;
      mis_q   <= mis_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (accept),
    .count (taken_count)
  );

  // Both pipeline registers are squashed together for the same window.
  assign pc           = pc_q;
  assign flush_ifid   = flush_q;
  assign flush_idex   = flush_q;
  assign misalign_err = mis_q;
  // Fetch is valid as soon as reset drops, except while its slot is squashed.
  assign pc_valid     = ~reset & ~flush_q;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench with an expectation queue: each step pushes the outputs
// expected after the coming edge, which are popped and compared after it.
module tb_branch_redirect_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic        br_taken = 1'b0;
  logic [63:0] br_target = 64'h0;

  logic [63:0] pc0, pc1;
  logic        pv0, pv1, fi0, fi1, fx0, fx1, me0, me1;
  logic [31:0] tc0;
  logic [1:0]  tc1;

  always #5 clk = ~clk;

  // Default configuration.
  branch_redirect_unit dut0 (
    .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
    .br_taken(br_taken), .br_target(br_target), .pc(pc0), .pc_valid(pv0),
    .flush_ifid(fi0), .flush_idex(fx0), .taken_count(tc0), .misalign_err(me0)
  );

  // Narrow counter, high reset PC, single-cycle flush.
  branch_redirect_unit #(
    .RESET_PC(64'hFFFF_FFFF_FFFF_FFF8), .FLUSH_CYCLES(1), .CNT_W(2)
  ) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
    .br_taken(br_taken), .br_target(br_target), .pc(pc1), .pc_valid(pv1),
    .flush_ifid(fi1), .flush_idex(fx1), .taken_count(tc1), .misalign_err(me1)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] pc;
    logic        pv;
    logic        fl;
    logic [31:0] cnt;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string tag, input int sel, input logic [63:0] p,
                      input logic v, input logic f, input logic [31:0] c,
                      input logic m);
    exp_t e;
    e.tag = tag; e.sel = sel; e.pc = p; e.pv = v; e.fl = f; e.cnt = c; e.mis = m;
    exp_q.push_back(e);
  endtask

  task automatic cmp1(input string tag, input string fld,
                      input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
    end
  endtask

  task automatic compare();
    exp_t e;
    logic [63:0] p;
    logic v, fi, fx, m;
    logic [31:0] c;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard empty observed=0 expected=1");
      return;
    end
    e = exp_q.pop_front();
    if (e.sel == 0) begin
      p = pc0; v = pv0; fi = fi0; fx = fx0; c = tc0; m = me0;
    end else begin
      p = pc1; v = pv1; fi = fi1; fx = fx1; c = {30'b0, tc1}; m = me1;
    end
    cmp1(e.tag, "pc", p, e.pc);
    cmp1(e.tag, "pc_valid", {63'b0, v}, {63'b0, e.pv});
    cmp1(e.tag, "flush_ifid", {63'b0, fi}, {63'b0, e.fl});
    cmp1(e.tag, "flush_idex", {63'b0, fx}, {63'b0, e.fl});
    cmp1(e.tag, "taken_count", {32'b0, c}, {32'b0, e.cnt});
    cmp1(e.tag, "misalign_err", {63'b0, m}, {63'b0, e.mis});
  endtask

  // Drive one cycle of inputs, record the expectation, clock, then check.
  task automatic step(input string tag, input int sel, input logic s,
                      input logic bv, input logic bt, input logic [63:0] tgt,
                      input logic [63:0] p, input logic v, input logic f,
                      input logic [31:0] c, input logic m);
    stall = s; br_valid = bv; br_taken = bt; br_target = tgt;
    push(tag, sel, p, v, f, c, m);
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    // ---------------- Config 0: defaults ----------------
    reset = 1'b1;
    step("rst0a", 0, 0, 0, 0, 0, 64'h0, 0, 0, 0, 0);
    step("rst0b", 0, 0, 0, 0, 0, 64'h0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    push("post_rst", 0, 64'h0, 1, 0, 0, 0);
    compare();
    step("seq4",  0, 0, 0, 0, 0, 64'h4,  1, 0, 0, 0);
    step("seq8",  0, 0, 0, 0, 0, 64'h8,  1, 0, 0, 0);
    step("seq12", 0, 0, 0, 0, 0, 64'hC,  1, 0, 0, 0);
    step("seq16", 0, 0, 0, 0, 0, 64'h10, 1, 0, 0, 0);
    // Taken branch at 0x10, then a second taken branch during the flush.
    step("br100",     0, 0, 1, 1, 64'h100, 64'h100, 0, 1, 1, 0);
    step("br_in_fl",  0, 0, 1, 1, 64'h200, 64'h104, 0, 1, 1, 0);
    step("fl_end",    0, 0, 0, 0, 0,       64'h108, 1, 0, 1, 0);
    step("bv0_taken", 0, 0, 0, 1, 64'h300, 64'h10C, 1, 0, 1, 0);
    // Reach 0x40, flush drains under stall.
    step("br40",      0, 0, 1, 1, 64'h40, 64'h40, 0, 1, 2, 0);
    step("fl_stall1", 0, 1, 0, 0, 0,      64'h40, 0, 1, 2, 0);
    step("fl_stall2", 0, 1, 0, 0, 0,      64'h40, 1, 0, 2, 0);
    // Redirect beats stall, then pc holds.
    step("br80_stl",  0, 1, 1, 1, 64'h80, 64'h80, 0, 1, 3, 0);
    step("hold80a",   0, 1, 0, 0, 0,      64'h80, 0, 1, 3, 0);
    step("hold80b",   0, 1, 0, 0, 0,      64'h80, 1, 0, 3, 0);
    step("hold80c",   0, 1, 0, 0, 0,      64'h80, 1, 0, 3, 0);
    // Misaligned target is aligned down and latches the sticky flag.
    step("br103",     0, 0, 1, 1, 64'h103, 64'h100, 0, 1, 4, 1);
    step("mis_a",     0, 0, 0, 0, 0,       64'h104, 0, 1, 4, 1);
    step("mis_b",     0, 0, 0, 0, 0,       64'h108, 1, 0, 4, 1);
    step("br20",      0, 0, 1, 1, 64'h20,  64'h20,  0, 1, 5, 1);
    step("sticky_a",  0, 0, 0, 0, 0,       64'h24,  0, 1, 5, 1);
    step("sticky_b",  0, 0, 0, 0, 0,       64'h28,  1, 0, 5, 1);
    // Reset in the middle of a flush.
    step("br500",     0, 0, 1, 1, 64'h500, 64'h500, 0, 1, 6, 1);
    reset = 1'b1;
    step("rst_midfl", 0, 0, 0, 0, 0,       64'h0,   0, 0, 0, 0);
    reset = 1'b0;
    step("after_rst", 0, 0, 0, 0, 0,       64'h4,   1, 0, 0, 0);

    // ---------------- Config 1: CNT_W=2, high RESET_PC, 1-cycle flush ----
    reset = 1'b1;
    step("rst1",   1, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    push("post_rst1", 1, 64'hFFFF_FFFF_FFFF_FFF8, 1, 0, 0, 0);
    compare();
    step("wrapFC", 1, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 0);
    step("wrap0",  1, 0, 0, 0, 0, 64'h0, 1, 0, 0, 0);
    step("wrap4",  1, 0, 0, 0, 0, 64'h4, 1, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      logic [63:0] t;
      t = 64'(i) << 8;
      step($sformatf("sat_br%0d", i), 1, 0, 1, 1, t, t, 0, 1,
           (i > 3) ? 32'd3 : 32'(i), 0);
      step($sformatf("sat_seq%0d", i), 1, 0, 0, 0, 0, t + 64'h4, 1, 0,
           (i > 3) ? 32'd3 : 32'(i), 0);
    end
    step("br600",    1, 0, 1, 1, 64'h600, 64'h600, 0, 1, 3, 0);
    step("ign_fl1",  1, 0, 1, 1, 64'h700, 64'h604, 1, 0, 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
- Consumes the branch-decision signal (taken / not-taken) and the branch target from the execute-stage branch check.
- Owns the 64-bit program counter: sequential PC+4 advance, stall hold, redirect on a taken branch.
- Generates pipeline flush pulses that squash wrong-path instructions in the fetch and decode stages.
- Keeps a saturating taken-branch counter and a sticky misaligned-target flag.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- FLUSH_CYCLES, 2, cycles flush stays asserted after a redirect; legal range 1..4.
- CNT_W, 32, width of the taken-branch counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit stall; hold PC when no redirect is pending.
- br_valid  in  1  branch-decision inputs are meaningful this cycle (execute-stage instruction is live).
- br_taken  in  1  branch decision (mux_sel from the branch check).
- br_target  in  64  branch target address.
- pc  out  64  current fetch PC.
- pc_valid  out  1  fetch at pc is on the correct path.
- flush_ifid  out  1  squash the IF/ID register.
- flush_idex  out  1  squash the ID/EX register.
- taken_count  out  CNT_W  number of accepted redirects, saturating.
- misalign_err  out  1  sticky flag: an accepted target had bit[1:0] != 0.

Behaviour:
- Reset: one clk edge with reset=1 sets the outputs as follows.
  - pc=RESET_PC, pc_valid=0, flush_ifid=0, flush_idex=0.
  - taken_count=0, misalign_err=0, state=RUN, flush counter=0.
  - pc_valid goes to 1 on the first cycle after reset deasserts.
  - reset overrides every other input, including mid-FLUSH.
- States: RUN, FLUSH.
- Accepted redirect: br_valid & br_taken while state==RUN. At the next edge:
  - pc <= {br_target[63:2],2'b00}.
  - flush_ifid=1 and flush_idex=1, registered, visible the cycle after acceptance.
  - state <= FLUSH, flush counter <= FLUSH_CYCLES-1.
  - taken_count increments; it holds at all-ones once saturated.
  - if br_target[1:0]!=0, misalign_err <= 1 and stays 1 until reset.
- Redirect has priority over stall: an accepted redirect updates pc even when stall=1.
- RUN, no redirect:
  - stall=1: pc holds.
  - stall=0: pc <= pc+64'd4, modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- FLUSH:
  - flush_ifid and flush_idex stay 1 while counter>0; counter decrements each cycle regardless of stall.
  - When counter==0 at an edge: flushes drop to 0 and state <= RUN.
  - Total flush assertion is exactly FLUSH_CYCLES cycles.
  - br_taken is ignored in FLUSH, since it comes from a squashed instruction: no redirect, no count.
  - pc advances by 4 per non-stalled cycle, as in RUN.
- pc_valid=0 while flush_ifid=1, otherwise 1 after reset.
- br_taken with br_valid=0 is ignored in every state.
- Flush latency: one cycle after acceptance. pc latency: one cycle.

Decomposition:
- Shared package holds:
  - state enum: RUN=1'b0, FLUSH=1'b1.
  - PC_STEP=64'd4.
  - default RESET_PC.
- One natural sub-module, sat_counter: width-parameterised saturating incrementer with sync reset. It is used for taken_count.
- The flush countdown stays inline.

Test Plan:
- Reset then run: reset 2 cycles, stall=0, no branches.
  - Required: pc=0, 4, 8, 12 on successive cycles.
  - Required: pc_valid=1 from the first post-reset cycle; flushes stay 0.
- Taken branch: at pc=0x10, pulse br_valid=1, br_taken=1, br_target=0x100 (FLUSH_CYCLES=2).
  - Required next cycle: pc=0x100, flush_ifid=flush_idex=1.
  - Required: flushes stay high for exactly 2 cycles; taken_count=1; pc=0x104, 0x108 follow.
- Branch during FLUSH: second br_taken=1 with target 0x200, one cycle after the first redirect.
  - Required: ignored; pc continues 0x104, no new flush, taken_count stays 1.
- Redirect under stall: stall=1 held, pc=0x40, taken branch to 0x80.
  - Required: pc=0x80 next cycle despite the stall; pc then holds at 0x80 while stall=1.
- Misaligned target plus saturation:
  - Target 0x103: pc=0x100 and misalign_err=1, sticky through later aligned branches.
  - With CNT_W=2, 5 accepted redirects: taken_count=3.
- Reset mid-FLUSH and wrap:
  - Assert reset on the flush cycle: next cycle pc=RESET_PC, flushes=0, state RUN, taken_count=0.
  - RESET_PC=64'hFFFF_FFFF_FFFF_FFF8: pc=...FFF8, ...FFFC, 0, 4.
